// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
// Y86-64 PIPE memory stage. Takes the M pipeline register fields from execute,
// performs one 8-byte little-endian access to the local data memory, drives the
// combinational forwarding values (m_valM, m_stat) back to decode, and loads
// the W pipeline register that feeds write-back.
//
// Parameters
//   MEM_BYTES : data memory size in bytes, legal addresses 0..MEM_BYTES-1
//   ADDR_W    : address/data width, 64 for Y86-64
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   M_stat .. M_dstM    : M register fields from execute
//   W_stall, W_bubble   : W register hold / bubble-insert controls
//   m_valM, m_stat      : combinational read data and stage status
//   W_stat .. W_dstM    : registered W pipeline fields
//
// Build option
//   MEM_ALIGN_CHECK_EN  : when defined, any access with addr[2:0] != 0 is an
//                         address error; otherwise unaligned accesses are
//                         byte-assembled like aligned ones.
// -----------------------------------------------------------------------------
module memory_stage #(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        M_stat,
    input  logic [3:0]        M_icode,
    input  logic              M_cnd,
    input  logic [ADDR_W-1:0] M_valE,
    input  logic [ADDR_W-1:0] M_valA,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic              W_stall,
    input  logic              W_bubble,
    output logic [ADDR_W-1:0] m_valM,
    output logic [2:0]        m_stat,
    output logic [2:0]        W_stat,
    output logic [3:0]        W_icode,
    output logic              W_cnd,
    output logic [ADDR_W-1:0] W_valE,
    output logic [ADDR_W-1:0] W_valM,
    output logic [3:0]        W_dstE,
    output logic [3:0]        W_dstM
);

    localparam logic [2:0] SBUB = 3'd0;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] INOP    = 4'd1;
    localparam logic [3:0] IRMMOVQ = 4'd4;
    localparam logic [3:0] IMRMOVQ = 4'd5;
    localparam logic [3:0] ICALL   = 4'd8;
    localparam logic [3:0] IRET    = 4'd9;
    localparam logic [3:0] IPUSHQ  = 4'd10;
    localparam logic [3:0] IPOPQ   = 4'd11;
    localparam logic [3:0] RNONE   = 4'd15;

    localparam int IDX_W = $clog2(MEM_BYTES);
    // Highest legal start address of an 8-byte access; anything above
    // (including wrapped "negative" addresses) runs off the array.
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_BYTES - 8);

    // A status already showing halt/fault in W freezes architectural memory.
    function automatic logic stat_blocks_write(input logic [2:0] stat);
        return (stat == SHLT) || (stat == SADR) || (stat == SINS);
    endfunction

    logic [7:0]        mem_r [MEM_BYTES];
    logic [ADDR_W-1:0] addr_s;
    logic [IDX_W-1:0]  idx_s;
    logic              mem_read_s;
    logic              mem_write_s;
    logic              dmem_error_s;
    logic [ADDR_W-1:0] rd_data_s;
    logic              wr_en_s;

    // Address select and read/write decode from the instruction code.
    always_comb begin
        addr_s      = M_valE;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        case (M_icode)
            IRMMOVQ, IPUSHQ, ICALL: begin
                addr_s      = M_valE;
                mem_write_s = 1'b1;
            end
            IMRMOVQ: begin
                addr_s     = M_valE;
                mem_read_s = 1'b1;
            end
            IPOPQ, IRET: begin
                addr_s     = M_valA;
                mem_read_s = 1'b1;
            end
            default: begin
                addr_s      = M_valE;
                mem_read_s  = 1'b0;
                mem_write_s = 1'b0;
            end
        endcase
    end

    assign idx_s = addr_s[IDX_W-1:0];

    // Address error: out of range, plus misalignment when that check is built in.
    always_comb begin
`ifdef MEM_ALIGN_CHECK_EN
        dmem_error_s = (mem_read_s || mem_write_s) &&
                       ((addr_s > ADDR_LIMIT) || (addr_s[2:0] != 3'd0));
`else
        dmem_error_s = (mem_read_s || mem_write_s) && (addr_s > ADDR_LIMIT);
`endif
    end

    // Little-endian 8-byte assembly; byte at the lowest address lands in bits 7:0.
    always_comb begin
        rd_data_s = '0;
        for (int i = 0; i < 8; i++) begin
            rd_data_s[8*i +: 8] = mem_r[idx_s + IDX_W'(i)];
        end
    end

    assign m_valM = (mem_read_s && !dmem_error_s) ? rd_data_s : '0;
    assign m_stat = dmem_error_s ? SADR : M_stat;

    // Stores commit only for a healthy instruction with no fault already in W;
    // W_stall deliberately does not gate the store.
    assign wr_en_s = mem_write_s && !dmem_error_s && (M_stat == SAOK) &&
                     !stat_blocks_write(W_stat) && !reset;

    // Data memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < 8; i++) begin
                mem_r[idx_s + IDX_W'(i)] <= M_valA[8*i +: 8];
            end
        end
    end

    // W pipeline register: reset > bubble > stall > load.
    always_ff @(posedge clk) begin
        if (reset || W_bubble) begin
            W_stat  <= SBUB;
            W_icode <= INOP;
            W_cnd   <= 1'b0;
            W_valE  <= '0;
            W_valM  <= '0;
            W_dstE  <= RNONE;
            W_dstM  <= RNONE;
        end else if (W_stall) begin
            W_stat  <= W_stat;
            W_icode <= W_icode;
            W_cnd   <= W_cnd;
            W_valE  <= W_valE;
            W_valM  <= W_valM;
            W_dstE  <= W_dstE;
            W_dstM  <= W_dstM;
        end else begin
            W_stat  <= m_stat;
            W_icode <= M_icode;
            W_cnd   <= M_cnd;
            W_valE  <= M_valE;
            W_valM  <= m_valM;
            W_dstE  <= M_dstE;
            W_dstM  <= M_dstM;
        end
    end

endmodule
